rotary_position_accum: RTL and testbench

//   Consumes one-cycle cw/ccw step pulses from the rotary encoder controller and

---
 rtl/rotary_position_accum_if.sv | 12 +
 rtl/rotary_position_accum.sv | 123 ++++++++++++
 tb/tb_rotary_position_accum.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rotary_position_accum_if.sv
// Avalon-MM slave bus for the rotary position accumulator register file.
// The CPU side uses master; the accumulator uses slave.
interface rotary_position_accum_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/rotary_position_accum.sv
// Rotary cursor position accumulator: steps on cw/ccw pulses, with wrap or saturate
// at the range ends and speed-based acceleration. CPU access is over a small Avalon-MM register file.
module rotary_position_accum #(
  parameter int WIDTH        = 8,
  parameter int MAX_POS      = 255,
  parameter int ACCEL_WINDOW = 250000,
  parameter int ACCEL_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rotary_cw,
  input  logic                   rotary_ccw,
  rotary_position_accum_if.slave avs,
  output logic [WIDTH-1:0]       position,
  output logic                   pos_changed
);

  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam logic [TW-1:0]  WIN    = TW'(ACCEL_WINDOW);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_POS);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(ACCEL_STEP);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

  logic            ctrl_wrap;
  logic            ctrl_accel;
  logic            limit_flag;
  logic            conflict_flag;
  logic [15:0]     evt_count;
  logic [TW-1:0]   gap_timer;

  logic            ev_inc;
  logic            ev_dec;
  logic            ev_conflict;
  logic            ev_any;
  logic            pos_write;
  logic            ctrl_write;
  logic            stat_read;
  logic            limit_hit;
  logic [WIDTH:0]  step;
  logic [WIDTH:0]  inc_sum;
  logic [WIDTH-1:0] next_pos;

  always_comb begin
    ev_inc      = rotary_cw & ~rotary_ccw;
    ev_dec      = rotary_ccw & ~rotary_cw;
    ev_conflict = rotary_cw & rotary_ccw;
    ev_any      = rotary_cw | rotary_ccw;
    pos_write   = avs.write && (avs.address == 2'd0);
    ctrl_write  = avs.write && (avs.address == 2'd1);
    stat_read   = avs.read && (avs.address == 2'd2);
    step        = (ctrl_accel && (gap_timer < WIN)) ? STEP_W : ONE_W;
    inc_sum     = {1'b0, position} + step;
    next_pos    = position;
    limit_hit   = 1'b0;
    // A CPU write to POSITION overrides any event in the same cycle.
    if (pos_write) begin
      next_pos = (avs.writedata > 32'(MAX_POS)) ? WIDTH'(MAX_W) : avs.writedata[WIDTH-1:0];
    end else if (ev_inc) begin
      if (inc_sum > MAX_W) begin
        limit_hit = 1'b1;
        next_pos  = ctrl_wrap ? WIDTH'(inc_sum - MAX_W - ONE_W) : WIDTH'(MAX_W);
      end else begin
        next_pos = WIDTH'(inc_sum);
      end
    end else if (ev_dec) begin
      if (step > {1'b0, position}) begin
        limit_hit = 1'b1;
        next_pos  = ctrl_wrap ? WIDTH'({1'b0, position} + MAX_W + ONE_W - step) : '0;
      end else begin
        next_pos = WIDTH'({1'b0, position} - step);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position      <= '0;
      pos_changed   <= 1'b0;
      ctrl_wrap     <= 1'b0;
      ctrl_accel    <= 1'b0;
      limit_flag    <= 1'b0;
      conflict_flag <= 1'b0;
      evt_count     <= '0;
      gap_timer     <= WIN;
      avs.readdata  <= '0;
    end else begin
      position    <= next_pos;
      pos_changed <= (next_pos != position);

      if (ctrl_write) begin
        ctrl_wrap  <= avs.writedata[0];
        ctrl_accel <= avs.writedata[1];
      end

      if (ev_any)
        gap_timer <= '0;
      else if (gap_timer != WIN)
        gap_timer <= gap_timer + 1'b1;

      // Read-clear keeps whatever arrives in the same cycle.
      if (stat_read) begin
        limit_flag    <= limit_hit;
        conflict_flag <= ev_conflict;
        evt_count     <= (ev_inc | ev_dec) ? 16'd1 : 16'd0;
      end else begin
        if (limit_hit)   limit_flag    <= 1'b1;
        if (ev_conflict) conflict_flag <= 1'b1;
        if ((ev_inc | ev_dec) && (evt_count != 16'hFFFF))
          evt_count <= evt_count + 16'd1;
      end

      if (avs.read) begin
        case (avs.address)
          2'd0:    avs.readdata <= 32'(position);
          2'd1:    avs.readdata <= {30'd0, ctrl_accel, ctrl_wrap};
          2'd2:    avs.readdata <= {evt_count, 14'd0, conflict_flag, limit_flag};
          default: avs.readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rotary_position_accum.sv
// Directed bench for rotary_position_accum with hand-computed expectations.
// The acceleration window is shortened to 100 cycles.
module tb_rotary_position_accum;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rotary_cw = 1'b0;
  logic       rotary_ccw = 1'b0;
  logic [7:0] position;
  logic       pos_changed;
  int         n_checks = 0;
  int         n_pass = 0;
  int         pc_count = 0;
  logic [31:0] rd;

  rotary_position_accum_if bus ();

  rotary_position_accum #(
    .WIDTH(8), .MAX_POS(255), .ACCEL_WINDOW(100), .ACCEL_STEP(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rotary_cw  (rotary_cw),
    .rotary_ccw (rotary_ccw),
    .avs        (bus.slave),
    .position   (position),
    .pos_changed(pos_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pos_changed) pc_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_pc();
    repeat (2) @(posedge clk);
    #1 pc_count = 0;
  endtask

  task automatic pulse(input logic cw, input logic ccw);
    @(negedge clk);
    rotary_cw = cw; rotary_ccw = ccw;
    @(negedge clk);
    rotary_cw = 1'b0; rotary_ccw = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  initial begin
    bus.address = 2'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_position", 32'(position), 32'd0);
    check("rst_pos_changed", 32'(pos_changed), 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    cpu_read(2'd1, rd); check("rst_ctrl", rd, 32'd0);
    cpu_read(2'd2, rd); check("rst_status", rd, 32'd0);

    // Slow steps, accel off
    clr_pc();
    pulse(1, 0); check("cw1", 32'(position), 32'd1);
    repeat (8) @(negedge clk);
    pulse(1, 0); check("cw2", 32'(position), 32'd2);
    repeat (8) @(negedge clk);
    pulse(1, 0); check("cw3", 32'(position), 32'd3);
    repeat (2) @(negedge clk);
    check("cw_pc_count", 32'(pc_count), 32'd3);
    cpu_read(2'd2, rd); check("status_cnt3", rd, 32'h0003_0000);

    // Saturate at top
    cpu_write(2'd0, 32'd254); check("wr_254", 32'(position), 32'd254);
    clr_pc();
    pulse(1, 0); check("sat1", 32'(position), 32'd255);
    pulse(1, 0); check("sat2", 32'(position), 32'd255);
    pulse(1, 0); check("sat3", 32'(position), 32'd255);
    repeat (2) @(negedge clk);
    check("sat_pc_count", 32'(pc_count), 32'd1);
    cpu_read(2'd2, rd); check("status_sat", rd, 32'h0003_0001);

    // Wrap going down; upper ctrl bits ignored
    cpu_write(2'd1, 32'hFFFF_FFFD);
    cpu_read(2'd1, rd); check("ctrl_wrap", rd, 32'd1);
    cpu_write(2'd0, 32'd1);
    pulse(0, 1); check("wrap1", 32'(position), 32'd0);
    pulse(0, 1); check("wrap2", 32'(position), 32'd255);
    pulse(0, 1); check("wrap3", 32'(position), 32'd254);
    cpu_read(2'd2, rd); check("status_wrap", rd, 32'h0003_0001);
    cpu_read(2'd2, rd); check("status_cleared", rd, 32'd0);

    // Acceleration: slow, fast, slow
    cpu_write(2'd1, 32'd2);
    cpu_write(2'd0, 32'd0);
    repeat (120) @(negedge clk);
    pulse(1, 0); check("accel_t0", 32'(position), 32'd1);
    repeat (48) @(negedge clk);
    pulse(1, 0); check("accel_t50", 32'(position), 32'd5);
    repeat (248) @(negedge clk);
    pulse(1, 0); check("accel_t300", 32'(position), 32'd6);
    cpu_read(2'd0, rd); check("pos_readback", rd, 32'd6);
    cpu_read(2'd2, rd); check("status_accel", rd, 32'h0003_0000);

    // cw and ccw together
    clr_pc();
    pulse(1, 1); check("conflict_pos", 32'(position), 32'd6);
    repeat (2) @(negedge clk);
    check("conflict_pc", 32'(pc_count), 32'd0);
    cpu_read(2'd2, rd); check("status_conflict", rd, 32'h0000_0002);

    // CPU write beats a same-cycle event; value clamped
    @(negedge clk);
    bus.address = 2'd0; bus.writedata = 32'h1FF; bus.write = 1'b1; rotary_cw = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; rotary_cw = 1'b0;
    check("wr_clamp_collide", 32'(position), 32'd255);
    cpu_read(2'd2, rd); check("status_dropped_evt", rd, 32'h0001_0000);
    cpu_write(2'd0, 32'd7); check("wr_7", 32'(position), 32'd7);

    // STATUS read colliding with an event (accel on, recent event -> fast)
    @(negedge clk);
    bus.address = 2'd2; bus.read = 1'b1; rotary_cw = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; rotary_cw = 1'b0;
    check("rd_collide_old", bus.readdata, 32'd0);
    check("rd_collide_pos", 32'(position), 32'd11);
    cpu_read(2'd2, rd); check("rd_collide_new", rd, 32'h0001_0000);

    // Reserved address
    cpu_write(2'd3, 32'hDEAD_BEEF);
    cpu_read(2'd3, rd); check("reserved", rd, 32'd0);

    // Reset mid-operation
    cpu_read(2'd0, rd);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pos", 32'(position), 32'd0);
    check("mid_rst_rd", bus.readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_read(2'd1, rd); check("mid_rst_ctrl", rd, 32'd0);
    cpu_read(2'd2, rd); check("mid_rst_status", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
